// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and the fetch state encoding shared by the fetch slice
package riscv_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered instruction buffer of {pc, instr} entries with flush
module fetch_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [63:0]              i_data,
   input  logic                     i_pop,
   output logic                     o_valid,
   output logic [63:0]              o_head,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_wr, w_rd;
   assign w_rd    = i_pop & (r_cnt != '0);
   // a full buffer still takes a push when the head leaves in the same cycle
   assign w_wr    = i_push & ((r_cnt != CW'(DEPTH)) | w_rd);
   assign o_valid = r_cnt != '0;
   assign o_head  = r_mem[r_rp];
   assign o_count = r_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_mem[r_wp] <= i_data;
         r_wp  <= r_wp + AW'(w_wr);
         r_rp  <= r_rp + AW'(w_rd);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based in-order instruction fetch with redirect, drop and halt
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misaligned
);
   localparam int          CW  = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW:0] LIM = (CW + 1)'(BUF_DEPTH);
   fetch_state_t  r_state, w_state_nx;
   logic [31:0]   r_fetch_pc, r_rsp_pc;
   logic [CW-1:0] r_out, r_drop, w_out_nx, w_cnt;
   logic [CW:0]   w_used;
   logic [63:0]   w_head;
   logic          w_fire, w_push, w_pop, w_aligned;
   assign w_aligned      = redirect_pc[1:0] == 2'b00;
   assign w_pop          = if_valid & if_ready;
   // the head leaving this cycle frees its slot for a new request
   assign w_used         = {1'b0, r_out} + {1'b0, w_cnt} - (CW + 1)'(w_pop);
   assign imem_req_valid = (r_state == ST_RUN) & ~redirect & (w_used < LIM);
   assign imem_req_addr  = r_fetch_pc;
   assign w_fire         = imem_req_valid & imem_req_ready;
   assign w_out_nx       = r_out + CW'(w_fire) - CW'(imem_rsp_valid);
   assign w_push         = imem_rsp_valid & ~redirect & (r_drop == '0);
   assign misaligned     = r_state == ST_HALT;
   assign if_pc          = w_head[63:32];
   assign if_instr       = w_head[31:0];
   always_comb begin
      w_state_nx = r_state;
      if (redirect) w_state_nx = w_aligned ? ST_RUN : ST_HALT;
      else if (r_state == ST_BOOT) w_state_nx = ST_RUN;
   end
   // responses return in order, so the next kept response belongs to r_rsp_pc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_out      <= '0;
         r_drop     <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_fetch_pc <= redirect ? redirect_pc : w_fire ? r_fetch_pc + 32'd4 : r_fetch_pc;
         r_rsp_pc   <= redirect ? redirect_pc : w_push ? r_rsp_pc + 32'd4 : r_rsp_pc;
         r_out      <= w_out_nx;
         r_drop     <= redirect ? w_out_nx :
                       (imem_rsp_valid && r_drop != '0) ? r_drop - CW'(1) : r_drop;
      end
   end
   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect),
      .i_push  (w_push),
      .i_data  ({r_rsp_pc, imem_rsp_data}),
      .i_pop   (w_pop),
      .o_valid (if_valid),
      .o_head  (w_head),
      .o_count (w_cnt)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory/decode traffic checked against an in-order PC stream model
module tb_fetch_unit;
   localparam int D = 2;
   logic        clk = 1'b0, rst = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        if_valid, if_ready = 1'b0;
   logic [31:0] if_pc, if_instr;
   logic        misaligned;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   fetch_unit #(.BUF_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instr(if_instr), .misaligned(misaligned)
   );
   logic [31:0] mem_q[$];
   int          fire_cyc[$];
   logic [31:0] fire_addr[$];
   logic [31:0] exp_pc, exp_req, last_fire;
   logic [63:0] hold_val;
   int          outst, cyc, n_pop, rsp_pct;
   bit          halted, hold_v, wrap_seen, have_last;
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0013_5A5A;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      logic fire, pop;
      #1;
      fire = imem_req_valid & imem_req_ready;
      pop  = if_valid & if_ready;
      if (redirect) chk("no_req_on_redirect", 64'(imem_req_valid), 64'd0);
      chk("misaligned_flag", 64'(misaligned), 64'(halted));
      if (halted) chk("halt_no_req", 64'(imem_req_valid), 64'd0);
      if (hold_v) begin
         chk("hold_valid", 64'(if_valid), 64'd1);
         chk("hold_data", {if_pc, if_instr}, hold_val);
      end
      hold_v   = if_valid & ~if_ready & ~redirect;
      hold_val = {if_pc, if_instr};
      if (fire) begin
         chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
         if (have_last && last_fire == 32'hFFFF_FFFC && imem_req_addr == 32'h0) wrap_seen = 1;
         last_fire = imem_req_addr;
         have_last = 1;
         exp_req  += 32'd4;
         mem_q.push_back(imem_req_addr);
         fire_cyc.push_back(cyc + 1);
         fire_addr.push_back(imem_req_addr);
         outst++;
      end
      if (imem_rsp_valid) outst--;
      chk("credit", 64'(outst <= D), 64'd1);
      if (pop) begin
         chk("if_pc", 64'(if_pc), 64'(exp_pc));
         chk("if_instr", 64'(if_instr), 64'(memf(exp_pc)));
         exp_pc += 32'd4;
         n_pop++;
      end
      if (redirect) begin
         exp_pc  = redirect_pc;
         exp_req = redirect_pc;
         halted  = redirect_pc[1:0] != 2'b00;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_misaligned", 64'(misaligned), 64'd0);
      chk("rst_if_pc", 64'(if_pc), 64'd0);
      chk("rst_if_instr", 64'(if_instr), 64'd0);
      chk("rst_req_addr", 64'(imem_req_addr), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mem_q.delete();
      fire_cyc.delete();
      fire_addr.delete();
      outst = 0; cyc = 0; exp_pc = 0; exp_req = 0;
      halted = 0; hold_v = 0; have_last = 0;
   endtask
   initial begin
      int n0;
      n_pop = 0; wrap_seen = 0; rsp_pct = 100;
      #2;
      do_reset();
      imem_req_ready = 1'b1; if_ready = 1'b1; rsp_pct = 100;
      repeat (6) step();
      chk("first_fire_cyc", 64'(fire_cyc[0]), 64'd2);
      chk("second_fire_cyc", 64'(fire_cyc[1]), 64'd3);
      chk("third_fire_cyc", 64'(fire_cyc[2]), 64'd4);
      chk("first_fire_addr", 64'(fire_addr[0]), 64'h0);
      chk("second_fire_addr", 64'(fire_addr[1]), 64'h4);
      chk("third_fire_addr", 64'(fire_addr[2]), 64'h8);
      chk("first_if_seen", 64'(n_pop > 0), 64'd1);
      if_ready = 1'b0;
      n0 = n_pop;
      repeat (10) step();
      chk("stall_if_valid", 64'(if_valid), 64'd1);
      chk("stall_no_pop", 64'(n_pop), 64'(n0));
      if_ready = 1'b1;
      repeat (8) step();
      chk("stall_release_pops", 64'(n_pop > n0), 64'd1);
      rsp_pct = 0;
      for (int k = 0; k < 10 && outst < 2; k++) step();
      chk("two_outstanding", 64'(outst), 64'd2);
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0; rsp_pct = 100;
      for (int k = 0; k < 20 && !if_valid; k++) step();
      chk("redir_if_valid", 64'(if_valid), 64'd1);
      chk("redir_head_pc", 64'(if_pc), 64'h100);
      repeat (4) step();
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      #1;
      chk("mis_flag", 64'(misaligned), 64'd1);
      chk("mis_no_req", 64'(imem_req_valid), 64'd0);
      repeat (4) step();
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      #1;
      chk("unhalt_flag", 64'(misaligned), 64'd0);
      chk("unhalt_req", 64'(imem_req_valid), 64'd1);
      chk("unhalt_addr", 64'(imem_req_addr), 64'h200);
      repeat (4) step();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0;
      step();
      redirect = 1'b0;
      repeat (14) step();
      chk("pc_wrap", 64'(wrap_seen), 64'd1);
      for (int k = 0; k < 600; k++) begin
         imem_req_ready = $urandom_range(3) != 0;
         if_ready       = $urandom_range(3) != 0;
         rsp_pct        = 70;
         redirect       = $urandom_range(halted ? 4 : 19) == 0;
         redirect_pc    = ($urandom_range(4) == 0) ? 32'hFFFF_FFE0 | ($urandom & 32'h1C) :
                          ($urandom & 32'h0000_0FFC);
         if ($urandom_range(5) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
         step();
      end
      redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b1; rsp_pct = 100;
      repeat (6) step();
      rsp_pct = 0; imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("one_outstanding", 64'(outst), 64'd1);
      do_reset();
      imem_req_ready = 1'b1; if_ready = 1'b1; rsp_pct = 100;
      n0 = n_pop;
      repeat (6) step();
      chk("restart_fire_cyc", 64'(fire_cyc[0]), 64'd2);
      chk("restart_fire_addr", 64'(fire_addr[0]), 64'h0);
      chk("restart_pops", 64'(n_pop > n0), 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction-buffer entries; legal values are 2 and 4.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports clk, rst.
REQ-004 Ports, in order:
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous active-high reset
 redirect  in  1  taken jump/branch; load redirect_pc
 redirect_pc  in  32  target from next-PC logic
 imem_req_valid  out  1  fetch request
 imem_req_ready  in  1  memory accepts request
 imem_req_addr  out  32  word address of request
 imem_rsp_valid  in  1  instruction word returned, in order
 imem_rsp_data  in  32  instruction word
 if_valid  out  1  buffer head valid to decode
 if_ready  in  1  decode accepts head
 if_pc  out  32  PC of head instruction
 if_instr  out  32  head instruction
 misaligned  out  1  redirect target not 4-byte aligned; fetch halted

Function
REQ-005 SHALL hold fetch_pc register; imem_req_addr = fetch_pc.
REQ-006 SHALL implement states BOOT, RUN, HALT; BOOT -> RUN after exactly one cycle; RUN -> HALT on redirect with redirect_pc[1:0] != 0; HALT -> RUN on aligned redirect.
REQ-007 SHALL assert imem_req_valid only in RUN, when not redirect, and when outstanding + buffered < BUF_DEPTH (credit rule).
REQ-008 Each accepted request (valid & ready) SHALL increment fetch_pc by 4, 32-bit wrap (32'hFFFF_FFFC -> 0) and increment outstanding.
REQ-009 Each imem_rsp_valid SHALL decrement outstanding; if drop counter > 0, decrement drop and discard; else push {pc, data} into buffer, pc taken from an in-order PC tag queue.
REQ-010 Buffer entry SHALL appear on if_valid the cycle after response arrives (registered); head pops on if_valid & if_ready.
REQ-011 On aligned redirect: fetch_pc <= redirect_pc; buffer flushed; drop <= outstanding count after this cycle's updates; request retracted that cycle (memory tolerates retraction).
REQ-012 Redirect coincident with request handshake: that request counted into drop; coincident with response: response discarded; coincident with if handshake: head counts as consumed, rest flushed.
REQ-013 Misaligned redirect: fetch_pc <= redirect_pc, buffer flushed, drop set as REQ-011, misaligned = 1 while in HALT, no requests.
REQ-014 Buffer full with if_ready = 0: no new requests (credit) ; if_pc/if_instr held stable while if_valid & !if_ready.
REQ-015 Push and pop same cycle on full buffer SHALL be legal, count unchanged.

Reset
REQ-016 Reset: state BOOT, fetch_pc = RESET_PC, outstanding = drop = buffer count = 0.
REQ-017 Reset outputs: imem_req_valid 0, if_valid 0, misaligned 0, if_pc 0, if_instr 0, imem_req_addr RESET_PC.
REQ-018 Reset mid-operation SHALL discard all in-flight and buffered state; responses after reset release are not expected.

Structure
REQ-019 RESET_PC default, NOP encoding 32'h0000_0013, and fetch state enum SHALL live in shared package riscv_pkg.
REQ-020 Buffer SHALL be sub-module fetch_fifo (parameterised depth, 64-bit {pc,instr} entries, flush input).

Verification
REQ-021 Reset release, imem ready always, 1-cycle response -> requests 0x0,0x4,0x8 on consecutive cycles starting cycle 2; if_pc 0x0 with if_instr matching.
REQ-022 if_ready = 0 for 10 cycles -> at most BUF_DEPTH outstanding+buffered; if_pc/if_instr stable; no lost or duplicated PC after release.
REQ-023 Redirect to 0x100 with 2 outstanding -> next 2 responses discarded; first if_pc after redirect is 0x100.
REQ-024 Redirect to 0x102 -> misaligned = 1, imem_req_valid = 0; later redirect to 0x200 -> misaligned = 0, fetch at 0x200.
REQ-025 fetch_pc 0xFFFF_FFFC accepted -> next request 0x0000_0000.
REQ-026 rst asserted mid-stream with 1 outstanding -> outputs at reset values same cycle; restart at RESET_PC.
